// File: rtl/mips_dbg_pkg.sv
// Shared types for the MIPS commit trace observer.
// State encoding and the 65-bit trace entry.
package mips_dbg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ARMED   = 2'b01,
      ST_CAPTURE = 2'b10,
      ST_DONE    = 2'b11
   } state_t;

   typedef struct packed {
      logic        last;
      logic [31:0] pc;
      logic [31:0] alu;
   } trace_t;

endpackage

// File: rtl/mips_trace_fifo.sv
// First-word-fall-through FIFO of trace entries.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module mips_trace_fifo
   import mips_dbg_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int FW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  trace_t        din,
   input  logic          pop,
   output trace_t        dout,
   output logic          full,
   output logic          empty,
   output logic [FW-1:0] fill
);

   trace_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [FW-1:0] cnt;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (cnt == '0);
   assign full    = (cnt == FW'(DEPTH));
   assign fill    = cnt;
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + FW'(push_ok) - FW'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mips_trace_capture.sv
// Commit trace capture: trigger FSM, sample and drop counters,
// and a FWFT buffer streaming (pc, alu) pairs to a debug host.
module mips_trace_capture
   import mips_dbg_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int LEN_W  = 16,
   parameter int DROP_W = 16,
   localparam int FW = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              arm,
   input  logic              abort,
   input  logic              trig_en,
   input  logic [31:0]       trig_pc,
   input  logic [LEN_W-1:0]  cap_len,
   input  logic              cpu_valid,
   input  logic [31:0]       pc_in,
   input  logic [31:0]       alu_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_alu,
   output logic              out_last,
   output logic [1:0]        state,
   output logic [FW-1:0]     fill,
   output logic [DROP_W-1:0] drop_cnt
);

   state_t            st_q;
   state_t            st_d;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [LEN_W-1:0]  cnt_inc;
   logic [DROP_W-1:0] drop_q;
   logic              arm_ok;
   logic              sample;
   logic              is_last;
   logic              pop;
   logic              full;
   logic              empty;
   logic              drains;
   trace_t            din;
   trace_t            dout;

   assign arm_ok  = arm && !abort && (st_q == ST_IDLE);
   assign sample  = cpu_valid && !abort &&
                    ((st_q == ST_CAPTURE) ||
                     ((st_q == ST_ARMED) && (pc_in == trig_pc)));
   assign cnt_inc = cnt_q + LEN_W'(1);
   assign is_last = (len_q != '0) && (cnt_inc == len_q);
   assign pop     = out_valid && out_ready;
   // leave DONE on the edge where the last entry is popped
   assign drains  = empty || ((fill == FW'(1)) && pop);

   assign din.last = is_last;
   assign din.pc   = pc_in;
   assign din.alu  = alu_in;

   assign out_valid = !empty;
   assign out_pc    = dout.pc;
   assign out_alu   = dout.alu;
   assign out_last  = dout.last;
   assign state     = st_q;
   assign drop_cnt  = drop_q;

   always_comb begin
      st_d = st_q;
      unique case (st_q)
         ST_IDLE: begin
            if (arm_ok) st_d = trig_en ? ST_ARMED : ST_CAPTURE;
         end
         ST_ARMED, ST_CAPTURE: begin
            if (sample) st_d = is_last ? ST_DONE : ST_CAPTURE;
         end
         ST_DONE: begin
            if (drains) st_d = ST_IDLE;
         end
         default: st_d = ST_IDLE;
      endcase
      if (abort) st_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= ST_IDLE;
         len_q  <= '0;
         cnt_q  <= '0;
         drop_q <= '0;
      end else begin
         st_q <= st_d;
         if (arm_ok) begin
            len_q  <= cap_len;
            cnt_q  <= '0;
            drop_q <= '0;
         end else if (sample) begin
            cnt_q <= cnt_inc;
            if (full && !pop && (drop_q != '1))
               drop_q <= drop_q + DROP_W'(1);
         end
      end
   end

   mips_trace_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .flush(abort),
      .push (sample),
      .din  (din),
      .pop  (pop),
      .dout (dout),
      .full (full),
      .empty(empty),
      .fill (fill)
   );

endmodule

// File: doc/mips_trace_capture.md
Name: mips_trace_capture

Overview:
- Synthesizable observer on the single-cycle MIPS core's commit outputs (pc_out, alu_result).
- Captures one (PC, ALU result) pair per committed instruction into an on-chip FIFO, optionally starting on a PC-match trigger.
- Streams entries out over a valid/ready interface to a debug host or UART bridge.
- Replaces waveform inspection with an in-design trace of the same two signals.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- LEN_W, 16, width of the capture-length counter and of cap_len.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- arm  input  1  one-cycle start request; honoured only in IDLE.
- abort  input  1  return to IDLE from any state and flush the FIFO.
- trig_en  input  1  1 = wait for a PC match; 0 = capture immediately.
- trig_pc  input  32  PC value that starts capture.
- cap_len  input  LEN_W  number of samples to capture; 0 = unlimited. Sampled when arm is accepted.
- cpu_valid  input  1  a commit occurred this cycle.
- pc_in  input  32  committed PC (core pc_out).
- alu_in  input  32  committed ALU result (core alu_result).
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head this cycle.
- out_pc  output  32  head PC.
- out_alu  output  32  head ALU result.
- out_last  output  1  head is the final sample of a bounded capture.
- state  output  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE.
- fill  output  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  output  DROP_W  samples lost to a full FIFO; saturates at all-ones.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; FIFO is empty.
  - out_valid = 0, out_pc = 0, out_alu = 0, out_last = 0, fill = 0, drop_cnt = 0.
  - Internal sample counter = 0.
- Reset mid-capture discards all FIFO contents.
- FSM:
  - IDLE + arm: latch cap_len and clear drop_cnt and the sample counter. Go to ARMED if trig_en = 1, else to CAPTURE.
  - ARMED: on cpu_valid && pc_in == trig_pc, go to CAPTURE. The matching sample is captured and counts as sample 1.
  - CAPTURE: every cpu_valid cycle is a sample; the counter increments whether the sample is stored or dropped. When the counter reaches the latched cap_len (nonzero), that sample gets last = 1 and state goes to DONE on the same edge. With cap_len = 0 the block stays in CAPTURE until abort.
  - DONE: no new samples. Go to IDLE on the cycle the FIFO becomes empty.
  - abort has priority over every other transition. It forces IDLE and empties the FIFO in one cycle. drop_cnt is held.
  - arm outside IDLE is ignored.
- FIFO:
  - First-word-fall-through; registered storage.
  - A sample pushed at edge N is visible (out_valid = 1) after edge N, i.e. one-cycle latency.
  - A pop occurs when out_valid && out_ready.
  - Push when full:
    - If a pop occurs in the same cycle, the push is accepted and fill is unchanged.
    - Otherwise the sample is dropped and drop_cnt increments (saturating).
  - A dropped sample that carries last = 1 still moves the FSM to DONE. A last entry is therefore never guaranteed to appear.
  - Read/write pointers wrap modulo DEPTH; fill is exact from 0 to DEPTH.
  - out_* outputs hold stable while out_valid = 1 and out_ready = 0.
- Simultaneous arm and abort: abort wins and arm is ignored.
- cpu_valid is ignored in IDLE and DONE.
- The PC compare is a full 32-bit equality; there is no masking.

Decomposition:
- Shared package mips_dbg_pkg holds:
  - the state encoding constants (ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DONE);
  - the 65-bit trace-entry struct {last, pc, alu}.
- One sub-module, mips_trace_fifo:
  - parameterised FWFT FIFO with push/pop, full/empty, flush and fill.
- Top level holds the FSM, trigger compare, sample counter and drop counter.

Test Plan:
- Reset, arm with trig_en = 0 and cap_len = 3, then cpu_valid on 3 cycles with pc 0x00, 0x04, 0x08 and alu 5, 7, 9, out_ready = 1 → three outputs in order, out_last = 1 only on (0x08, 9), state returns to IDLE once fill = 0.
- Arm with trig_en = 1, trig_pc = 0x10, cap_len = 2, PCs 0x00, 0x04 … 0x18 → ARMED until pc 0x10; captured entries are 0x10 and 0x14 only.
- DEPTH = 16, cap_len = 0, out_ready = 0, 20 commits → fill = 16, drop_cnt = 4. Then out_ready = 1 → the 16 oldest entries drain in order.
- Full FIFO with out_ready = 1 and cpu_valid in the same cycle → push accepted, fill stays 16, drop_cnt unchanged.
- Abort in CAPTURE with fill = 5 → next cycle state = IDLE, fill = 0, out_valid = 0. arm asserted with abort is ignored.
- rst_n asserted low between clock edges in CAPTURE → outputs clear immediately, without waiting for a clock edge.
